// File: rtl/mlp_pkg.sv
// Shared types and default widths for the MLP datapath.
// Holds the operand-sequencer state encoding and the DSP operand/result width defaults.
package mlp_pkg;

  localparam int MLP_XW    = 25;
  localparam int MLP_WW    = 18;
  localparam int MLP_DW    = 27;
  localparam int MLP_LEN_W = 10;
  localparam int MLP_NEU_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    FETCH,
    DRAIN,
    RESULT
  } state_t;

endpackage

// File: rtl/vld_delay.sv
// Valid pipeline: delays the buffer read strobe to line up with returning read data.
// Latency DEPTH cycles; no backpressure; clears to 0 on reset.
module vld_delay #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/mac_sequencer.sv
// Streams (x, w) operand pairs into the DSP MAC per neuron, flushes it and returns each sum.
// Per neuron: 1 clear + vec_len fetch + RAM_LAT+MAC_LAT drain cycles; holds the result while res_ready=0.
module mac_sequencer
  import mlp_pkg::*;
#(
  parameter int XW      = MLP_XW,
  parameter int WW      = MLP_WW,
  parameter int DW      = MLP_DW,
  parameter int LEN_W   = MLP_LEN_W,
  parameter int NEU_W   = MLP_NEU_W,
  parameter int RAM_LAT = 1,
  parameter int MAC_LAT = 2
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic [LEN_W-1:0]       vec_len,
  input  logic [NEU_W-1:0]       num_neu,
  output logic                   busy,
  output logic                   done,
  output logic                   rd_en,
  output logic [LEN_W-1:0]       x_addr,
  output logic [LEN_W+NEU_W-1:0] w_addr,
  input  logic [XW-1:0]          x_rdata,
  input  logic [WW-1:0]          w_rdata,
  output logic                   mac_enable,
  output logic                   mac_clear,
  output logic [XW-1:0]          mac_xin,
  output logic [WW-1:0]          mac_win,
  input  logic [DW-1:0]          mac_dout,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [DW-1:0]          res_data,
  output logic [NEU_W-1:0]       res_idx
);

  localparam int AW      = LEN_W + NEU_W;
  localparam int DRAIN_N = RAM_LAT + MAC_LAT;
  localparam int DCW     = $clog2(DRAIN_N + 1);

  state_t            state, state_nxt;
  logic [LEN_W-1:0]  len_q;
  logic [NEU_W-1:0]  neu_q;
  logic [LEN_W-1:0]  k;
  logic [NEU_W-1:0]  n;
  logic [AW-1:0]     w_base;
  logic [DCW-1:0]    dcnt;
  logic              op_vld;
  logic              fetch_last;
  logic              drain_last;
  logic              last_neu;
  logic              accept;
  logic              cfg_zero;

  // len_q and neu_q are nonzero whenever these compares matter (zero configs never leave IDLE).
  assign fetch_last = (k == len_q - LEN_W'(1));
  assign last_neu   = (n == neu_q - NEU_W'(1));
  assign drain_last = (dcnt == DCW'(DRAIN_N - 1));
  assign accept     = res_valid & res_ready;
  assign cfg_zero   = (vec_len == '0) || (num_neu == '0);

  vld_delay #(
    .DEPTH (RAM_LAT)
  ) u_vld_delay (
    .clk  (clk),
    .rstn (rstn),
    .din  (rd_en),
    .dout (op_vld)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    busy       = 1'b1;
    rd_en      = 1'b0;
    mac_clear  = 1'b0;
    x_addr     = '0;
    w_addr     = '0;
    mac_enable = op_vld;
    mac_xin    = op_vld ? x_rdata : '0;
    mac_win    = op_vld ? w_rdata : '0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start && !cfg_zero) state_nxt = CLR;
      end
      CLR: begin
        mac_clear = 1'b1;
        state_nxt = FETCH;
      end
      FETCH: begin
        rd_en  = 1'b1;
        x_addr = k;
        w_addr = w_base + AW'(k);
        if (fetch_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        // Zero operands keep the sum fixed while the DSP pipeline advances.
        mac_enable = 1'b1;
        if (drain_last) state_nxt = RESULT;
      end
      RESULT: begin
        if (accept) state_nxt = last_neu ? IDLE : CLR;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      len_q     <= '0;
      neu_q     <= '0;
      k         <= '0;
      n         <= '0;
      w_base    <= '0;
      dcnt      <= '0;
      done      <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_idx   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            len_q  <= vec_len;
            neu_q  <= num_neu;
            n      <= '0;
            w_base <= '0;
            if (cfg_zero) done <= 1'b1;
          end
        end
        CLR: begin
          k    <= '0;
          dcnt <= '0;
        end
        FETCH: begin
          if (!fetch_last) k <= k + LEN_W'(1);
        end
        DRAIN: begin
          dcnt <= dcnt + DCW'(1);
          if (drain_last) begin
            res_data  <= mac_dout;
            res_idx   <= n;
            res_valid <= 1'b1;
          end
        end
        RESULT: begin
          if (accept) begin
            res_valid <= 1'b0;
            if (last_neu) begin
              done <= 1'b1;
            end else begin
              n      <= n + NEU_W'(1);
              w_base <= w_base + AW'(len_q);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
